// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample factor, default divisor and FIFO entry layout.
package uart_pkg;

  localparam int OVS = 16;

  // Oversample period in clk cycles for a given system clock and baud rate.
  function automatic int div_for(input int clk_hz, input int baud);
    return clk_hz / (baud * OVS);
  endfunction

  // 50 MHz system clock at 115200 baud gives 27.
  localparam int DIV_RST = div_for(50_000_000, 115_200);

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Downstream byte stream: valid/ready handshake carrying a byte and its framing-error flag.
interface uart_rx_ctrl_if;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_ready;

  modport master (output m_valid, output m_data, output m_ferr, input m_ready);
  modport slave  (input m_valid, input m_data, input m_ferr, output m_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: runtime divisor latched once per period, clamped to at least 2.
module uart_baud_gen #(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_en,
  input  logic [DIV_W-1:0] div,
  output logic             s_tick
);

  localparam int PER_RST = (DIV_RST < 2) ? 2 : DIV_RST;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_clamped;
  logic             tick_q, tick_d;

  // Count through one period; at the last count reload, latch the new period and raise the tick.
  always_comb begin
    div_clamped = (div < DIV_W'(2)) ? DIV_W'(2) : div;
    cnt_d       = cnt_q;
    per_d       = per_q;
    tick_d      = 1'b0;
    if (baud_en) begin
      if (cnt_q == per_q - DIV_W'(1)) begin
        cnt_d  = '0;
        per_d  = div_clamped;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Counter, latched period and registered tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= DIV_W'(PER_RST);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end

  assign s_tick = tick_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generation, byte capture into a show-ahead FIFO, overrun accounting.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = uart_pkg::DIV_RST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_en,
  input  logic [DIV_W-1:0]              div,
  output logic                          s_tick,
  input  logic                          rx_line,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_dout,
  uart_rx_ctrl_if.master                m,
  input  logic                          clr,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic [7:0]                    ovr_cnt
);

  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  uart_baud_gen #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud_en (baud_en),
    .div     (div),
    .s_tick  (s_tick)
  );

  uart_entry_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        ovr_cnt_q, ovr_cnt_d;
  uart_entry_t       head_q, head_d;
  uart_entry_t       in_entry;
  logic              full, pop, push_ok, drop, wr_en;

  // Pointer, occupancy, overrun and head-register update; clr overrides any push or pop.
  always_comb begin
    in_entry  = '{ferr: ~rx_line, data: rx_dout};
    full      = (level_q == LW'(FIFO_DEPTH));
    pop       = (level_q != '0) && m.m_ready;
    push_ok   = rx_done_tick && (!full || pop);
    drop      = rx_done_tick && full && !pop;
    wr_en     = 1'b0;
    wr_d      = wr_q;
    rd_d      = rd_q;
    level_d   = level_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    head_d    = head_q;
    if (clr) begin
      wr_d      = '0;
      rd_d      = '0;
      level_d   = '0;
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end else begin
      wr_en = push_ok;
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      if (push_ok) begin
        wr_d = wr_q + AW'(1);
      end
      level_d = level_q + LW'(push_ok) - LW'(pop);
      if (drop) begin
        ovr_d = 1'b1;
        if (ovr_cnt_q != 8'hFF) begin
          ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
      end
      if (level_d != '0) begin
        head_d = (push_ok && (wr_q == rd_d)) ? in_entry : mem_q[rd_d];
      end
    end
  end

  // FIFO storage, pointers, status and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      head_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= in_entry;
      end
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      head_q    <= head_d;
    end
  end

  assign m.m_valid = (level_q != '0);
  assign m.m_data  = head_q.data;
  assign m.m_ferr  = head_q.ferr;
  assign level     = level_q;
  assign overrun   = ovr_q;
  assign ovr_cnt   = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: tick timing, directed FIFO vectors, random traffic vs a queue model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             baud_en = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             rx_line = 1'b1;
  logic             rx_done_tick = 1'b0;
  logic [7:0]       rx_dout = '0;
  logic             clr = 1'b0;
  logic             s_tick;
  logic [3:0]       level;
  logic             overrun;
  logic [7:0]       ovr_cnt;

  uart_rx_ctrl_if stream ();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_en      (baud_en),
    .div          (div),
    .s_tick       (s_tick),
    .rx_line      (rx_line),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .m            (stream),
    .clr          (clr),
    .level        (level),
    .overrun      (overrun),
    .ovr_cnt      (ovr_cnt)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as {ferr, data}, sticky overrun and saturating drop count.
  logic [8:0] mq[$];
  bit         m_ovr = 0;
  int         m_cnt = 0;

  typedef struct {
    logic       done;
    logic [7:0] dout;
    logic       line;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    int         exp_level;
  } vec_t;

  vec_t tbl[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same event, then clock the DUT.
  task automatic applyStimulus(input logic done, input logic [7:0] dout, input logic line,
                               input logic ready, input logic c);
    bit full;
    bit pop;
    rx_done_tick   = done;
    rx_dout        = dout;
    rx_line        = line;
    stream.m_ready = ready;
    clr            = c;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && ready;
    if (c) begin
      mq.delete();
      m_ovr = 0;
      m_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) begin
        if (full && !pop) begin
          m_ovr = 1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          mq.push_back({~line, dout});
        end
      end
    end
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    logic [8:0] head;
    checkOutput({tag, ".level"}, 32'(level), 32'(mq.size()));
    checkOutput({tag, ".valid"}, 32'(stream.m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      checkOutput({tag, ".data"}, 32'(stream.m_data), 32'(head[7:0]));
      checkOutput({tag, ".ferr"}, 32'(stream.m_ferr), 32'(head[8]));
    end
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    checkOutput({tag, ".ovr_cnt"}, 32'(ovr_cnt), 32'(m_cnt));
  endtask

  task automatic waitTick(output int n, input int budget);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (s_tick) return;
      if (n >= budget) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic drainCheck(input string tag, input logic [7:0] exp);
    checkOutput({tag, ".valid"}, 32'(stream.m_valid), 32'd1);
    checkOutput({tag, ".data"}, 32'(stream.m_data), 32'(exp));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    stream.m_ready = 1'b0;
    baud_en = 1'b1;
    div     = 16'd4;

    tbl[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    tbl[2] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b1, 1};
    tbl[3] = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 1'b1, 2};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 1};
    tbl[5] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.s_tick", 32'(s_tick), 32'd0);
    checkOutput("rst.valid", 32'(stream.m_valid), 32'd0);
    checkOutput("rst.data", 32'(stream.m_data), 32'd0);
    checkOutput("rst.ferr", 32'(stream.m_ferr), 32'd0);
    checkOutput("rst.level", 32'(level), 32'd0);
    checkOutput("rst.overrun", 32'(overrun), 32'd0);
    checkOutput("rst.ovr_cnt", 32'(ovr_cnt), 32'd0);
    rst_n = 1'b1;

    // Tick generator: reset period, steady period, mid-period divisor change, clamp, re-enable.
    waitTick(n, 100); checkOutput("tick.first", 32'(n), 32'd27);
    for (int i = 0; i < 3; i++) begin
      waitTick(n, 100); checkOutput("tick.p4", 32'(n), 32'd4);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("tick.mid_low", 32'(s_tick), 32'd0);
    div = 16'd10;
    waitTick(n, 100); checkOutput("tick.finish4", 32'(n), 32'd2);
    waitTick(n, 100); checkOutput("tick.p10", 32'(n), 32'd10);
    div = 16'd0;
    waitTick(n, 100); checkOutput("tick.p10b", 32'(n), 32'd10);
    waitTick(n, 100); checkOutput("tick.clamp", 32'(n), 32'd2);
    waitTick(n, 100); checkOutput("tick.clamp2", 32'(n), 32'd2);
    div = 16'd5;
    waitTick(n, 100); checkOutput("tick.p2last", 32'(n), 32'd2);
    waitTick(n, 100); checkOutput("tick.p5", 32'(n), 32'd5);
    baud_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checkOutput("tick.disabled", 32'(s_tick), 32'd0);
    end
    baud_en = 1'b1;
    waitTick(n, 100); checkOutput("tick.reenable", 32'(n), 32'd5);
    baud_en = 1'b0;

    // Directed vectors: capture, framing error, show-ahead pop, pop+push at level 1.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].done, tbl[i].dout, tbl[i].line, tbl[i].ready, tbl[i].clr);
      checkOutput($sformatf("vec%0d.valid", i), 32'(stream.m_valid), 32'(tbl[i].exp_valid));
      checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].exp_level));
      if (tbl[i].exp_valid) begin
        checkOutput($sformatf("vec%0d.data", i), 32'(stream.m_data), 32'(tbl[i].exp_data));
        checkOutput($sformatf("vec%0d.ferr", i), 32'(stream.m_ferr), 32'(tbl[i].exp_ferr));
      end
    end

    // Overrun: ten bytes into eight slots, then drain in order.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    checkOutput("ovr.level", 32'(level), 32'd8);
    checkOutput("ovr.overrun", 32'(overrun), 32'd1);
    checkOutput("ovr.ovr_cnt", 32'(ovr_cnt), 32'd2);
    for (int i = 0; i < 8; i++) drainCheck("ovr.drain", 8'(i));
    checkOutput("ovr.empty", 32'(stream.m_valid), 32'd0);

    // Full with simultaneous push and pop: nothing dropped, pushed byte drains last.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    checkOutput("fullpp.level", 32'(level), 32'd8);
    checkOutput("fullpp.ovr_cnt", 32'(ovr_cnt), 32'd2);
    for (int i = 1; i < 8; i++) drainCheck("fullpp.drain", 8'(8'h10 + i));
    drainCheck("fullpp.last", 8'hAA);

    // Saturation of the drop counter, then clr racing a push at level 3.
    for (int i = 0; i < 268; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("sat.ovr_cnt", 32'(ovr_cnt), 32'd255);
    checkModel("sat");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("preclr.level", 32'(level), 32'd3);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    checkOutput("clr.level", 32'(level), 32'd0);
    checkOutput("clr.valid", 32'(stream.m_valid), 32'd0);
    checkOutput("clr.ovr_cnt", 32'(ovr_cnt), 32'd0);
    checkOutput("clr.overrun", 32'(overrun), 32'd0);

    // Random traffic with alternating consumer stall phases, checked against the queue model.
    for (int i = 0; i < 1500; i++) begin
      logic rdy;
      rdy = ((i / 300) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      applyStimulus($urandom_range(2) == 0, 8'($urandom), $urandom_range(7) != 0, rdy,
                    $urandom_range(199) == 0);
      checkModel("rand");
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    baud_en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.s_tick", 32'(s_tick), 32'd0);
    checkOutput("arst.valid", 32'(stream.m_valid), 32'd0);
    checkOutput("arst.data", 32'(stream.m_data), 32'd0);
    checkOutput("arst.ferr", 32'(stream.m_ferr), 32'd0);
    checkOutput("arst.level", 32'(level), 32'd0);
    checkOutput("arst.overrun", 32'(overrun), 32'd0);
    checkOutput("arst.ovr_cnt", 32'(ovr_cnt), 32'd0);
    mq.delete();
    m_ovr = 0;
    m_cnt = 0;
    baud_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkModel("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the 16x-oversampling UART receiver. It generates the `s_tick` oversample strobe from a runtime baud divisor and captures each completed byte on `rx_done_tick`, flagging framing errors. Bytes are buffered in a small FIFO and presented downstream on a valid/ready stream. It sits between the UART receiver and the ASCII command/consumer logic, and accounts for overruns when the consumer stalls.

## Interface
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two, ≥2
- `DIV_W`, 16, width of baud divisor
- `DIV_RST`, 27, divisor loaded at reset (50 MHz / 115200 / 16)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `baud_en`  in  1  enables tick generation
- `div`  in  DIV_W  oversample period in clk cycles
- `s_tick`  out  1  one-cycle oversample strobe to the receiver
- `rx_line`  in  1  synchronised serial line, same signal the receiver samples
- `rx_done_tick`  in  1  receiver byte-complete pulse
- `rx_dout`  in  8  receiver data, valid while `rx_done_tick`=1
- `m_valid`  out  1  head byte available
- `m_data`  out  8  head byte
- `m_ferr`  out  1  framing-error flag of head byte
- `m_ready`  in  1  consumer accepts head byte
- `clr`  in  1  synchronous flush of FIFO and error status
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `overrun`  out  1  sticky; a byte was dropped
- `ovr_cnt`  out  8  dropped-byte count, saturating at 255

## Operation
- Tick generator: counter `cnt` runs 0..P-1; `s_tick`=1 when `cnt`=P-1, then `cnt` reloads to 0.
  - P is latched from `div` at reset (`DIV_RST`) and at each wrap, so a `div` change takes effect at the next period.
  - Latched `div`<2 is clamped to P=2.
- `baud_en`=0: `cnt` is held at 0 and `s_tick`=0; on re-enable, the first tick arrives P cycles later.
- Capture: when `rx_done_tick`=1, push the 9-bit entry `{~rx_line, rx_dout}`. `rx_line`=0 at stop-bit end means a framing error; the byte is still stored.
- Pop: `m_valid && m_ready` removes the head.
- Full and push with no pop: the byte is dropped, `overrun` is set, and `ovr_cnt` increments, saturating at 255.
- Full, push and pop in the same cycle: both happen; no drop; `level` is unchanged.
- Empty and push: `m_valid` rises next cycle. Pop cannot occur while empty.
- `clr`=1: pointers, `level`, `overrun` and `ovr_cnt` go to 0. `clr` beats a simultaneous push or pop; that byte is discarded and not counted.
- Pointers wrap modulo `FIFO_DEPTH`. `level` ranges 0..`FIFO_DEPTH`.
- `m_data`/`m_ferr` are stable while `m_valid`=1 and `m_ready`=0. They are don't-care, held at last value, when `m_valid`=0.

## Timing
- Reset values: `s_tick`=0, `m_valid`=0, `m_data`=0, `m_ferr`=0, `level`=0, `overrun`=0, `ovr_cnt`=0, `cnt`=0, P=`DIV_RST`.
- Push to `m_valid`: 1 cycle (show-ahead head register).
- Pop to next head valid: 0 cycles; if `level`≥2, the next byte is presented in the cycle after acceptance.
- `level`, `overrun` and `ovr_cnt` update in the cycle after the causing event.
- `s_tick` period is exactly P clk cycles with no jitter. It is registered, not combinational.
- Reset mid-frame: all state clears immediately; the receiver is reset by the same `rst_n`.

## Structure
- Shared package `uart_pkg`:
  - `OVS`=16 oversample factor
  - `DIV_RST` default
  - `uart_entry_t` = {ferr, data[7:0]}
  - `div_for(clk_hz, baud)` constant function
- Sub-module `uart_baud_gen`: tick counter, divisor latch, clamp.
- FIFO storage and status stay in `uart_rx_ctrl`.

## Test plan
- `div`=4, `baud_en`=1 from reset: `s_tick` pulses every 4 cycles. Change `div` to 10 mid-period: the current period completes at 4, then period is 10. `div`=0 gives period 2.
- Pulse `rx_done_tick` with `rx_dout`=0x41, `rx_line`=1: `m_valid`=1 next cycle, `m_data`=0x41, `m_ferr`=0, `level`=1.
- Same push with `rx_line`=0: `m_ferr`=1 and the byte is retained.
- `m_ready`=0, push 10 bytes 0x00..0x09 into depth 8: `level`=8, `overrun`=1, `ovr_cnt`=2. Drain: 0x00..0x07 in order.
- FIFO full, push 0xAA with simultaneous pop: no drop, `level` stays 8, and 0xAA is the last drained byte.
- `clr` coincident with push while `level`=3: next cycle `level`=0, `m_valid`=0, `ovr_cnt`=0. Assert `rst_n` low mid-stream: all outputs return to reset values asynchronously.
